// File: rtl/fpu_result_fifo_if.sv
// fpu_result_fifo_if: handshake and data bundle around the FPU result FIFO.
//   Upstream  : Req_SI / Ack_SO with Result_DI, Flags_DI, Tag_DI
//   Writeback : Valid_SO / Ready_SI with Result_DO, Flags_DO, Tag_DO
//   Status    : Count_SO (fill level), Sticky_SO {IV,IX,UF,OF}, ClrSticky_SI
// Modport slave is the FIFO side; master is the environment driving it.
interface fpu_result_fifo_if #(
    parameter int DEPTH     = 4,
    parameter int TAG_WIDTH = 7
);
    logic                       Req_SI;
    logic                       Ack_SO;
    logic [31:0]                Result_DI;
    logic [8:0]                 Flags_DI;
    logic [TAG_WIDTH-1:0]       Tag_DI;
    logic                       Valid_SO;
    logic                       Ready_SI;
    logic [31:0]                Result_DO;
    logic [8:0]                 Flags_DO;
    logic [TAG_WIDTH-1:0]       Tag_DO;
    logic [$clog2(DEPTH):0]     Count_SO;
    logic [3:0]                 Sticky_SO;
    logic                       ClrSticky_SI;

    modport slave (
        input  Req_SI, Result_DI, Flags_DI, Tag_DI, Ready_SI, ClrSticky_SI,
        output Ack_SO, Valid_SO, Result_DO, Flags_DO, Tag_DO, Count_SO, Sticky_SO
    );

    modport master (
        output Req_SI, Result_DI, Flags_DI, Tag_DI, Ready_SI, ClrSticky_SI,
        input  Ack_SO, Valid_SO, Result_DO, Flags_DO, Tag_DO, Count_SO, Sticky_SO
    );
endinterface

// File: rtl/fpu_result_fifo.sv
// fpu_result_fifo: small FIFO buffering FPU result beats toward writeback,
// with sticky IEEE exception flags for the fcsr.
//   Clk_CI : clock, all state on rising edge
//   Rst_RI : asynchronous active-high reset
//   bus    : fpu_result_fifo_if.slave (push side, pop side, count, sticky)
// Ack_SO/Valid_SO depend only on registered state, so there is no
// combinational path from Req_SI or Ready_SI to either handshake output.
module fpu_result_fifo #(
    parameter int DEPTH     = 4,
    parameter int TAG_WIDTH = 7
) (
    input  logic               Clk_CI,
    input  logic               Rst_RI,
    fpu_result_fifo_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0]          result;
        logic [8:0]           flags;
        logic [TAG_WIDTH-1:0] tag;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      sticky_q, sticky_d;
    logic            push, pop;
    entry_t          head;

    assign bus.Ack_SO   = (cnt_q != CW'(DEPTH));
    assign bus.Valid_SO = (cnt_q != '0);
    assign push         = bus.Req_SI & bus.Ack_SO;
    assign pop          = bus.Valid_SO & bus.Ready_SI;

    assign head          = mem_q[rptr_q];
    assign bus.Result_DO = head.result;
    assign bus.Flags_DO  = head.flags;
    assign bus.Tag_DO    = head.tag;
    assign bus.Count_SO  = cnt_q;
    assign bus.Sticky_SO = sticky_q;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        // Clear drops the old accumulation but a same-cycle push still lands.
        sticky_d = bus.ClrSticky_SI ? 4'b0 : sticky_q;
        if (push)
            sticky_d = sticky_d | {bus.Flags_DI[6], bus.Flags_DI[5],
                                   bus.Flags_DI[1], bus.Flags_DI[0]};
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            sticky_q <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q].result <= bus.Result_DI;
                mem_q[wptr_q].flags  <= bus.Flags_DI;
                mem_q[wptr_q].tag    <= bus.Tag_DI;
                wptr_q               <= wptr_q + PW'(1);
            end
            if (pop) rptr_q <= rptr_q + PW'(1);
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end
endmodule
